// File: rtl/tile_collision_scanner.sv
// tile_collision_scanner: per-frame sprite bounding-box tile scan with held bounce outputs (optional COLLISION_HITCOUNT_EN)
module tile_collision_scanner #(
  parameter int MAP_W       = 64,
  parameter int MAP_H       = 48,
  parameter int TILE_PX     = 10,
  parameter int COORD_W     = 20,
  parameter int DIM_W       = 10,
  parameter int BOUNCE_HOLD = 8,
  parameter int CNT_W       = 12
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   start,
  input  logic [MAP_W*MAP_H-1:0] map,
  input  logic [COORD_W-1:0]     spriteX,
  input  logic [COORD_W-1:0]     spriteY,
  input  logic [DIM_W-1:0]       spriteWidth,
  input  logic [DIM_W-1:0]       spriteHeight,
  input  logic                   left,
  input  logic                   right,
  input  logic                   up,
  input  logic                   down,
  output logic                   busy,
  output logic                   done,
  output logic                   bounceLeft,
  output logic                   bounceRight,
  output logic                   bounceUp,
  output logic                   bounceDown,
  output logic                   collision,
  output logic [CNT_W-1:0]       hit_count
);
  localparam int SW = COORD_W + 1;
  localparam int XW = $clog2(MAP_W);
  localparam int YW = $clog2(MAP_H);
  localparam int IW = $clog2(MAP_W * MAP_H);
  localparam int HW = $clog2(BOUNCE_HOLD + 1);
  typedef enum logic [1:0] {IDLE, LATCH, SCAN, RESOLVE} state_t;
  state_t r_state, w_next;
  logic [XW-1:0] r_x0, r_x1, r_tx, w_x0, w_x1;
  logic [YW-1:0] r_y0, r_y1, r_ty, w_y0, w_y1;
  logic [SW-1:0] w_x0r, w_x1r, w_y0r, w_y1r;
  logic r_oob_r, r_oob_b, r_dl, r_dr, r_du, r_dd;
  logic r_hit_l, r_hit_r, r_hit_t, r_hit_b, r_hit_any;
  logic [IW-1:0] w_idx;
  logic w_solid, w_last, w_trig_l, w_trig_r, w_trig_u, w_trig_d;
  logic [HW-1:0] r_hold_l, r_hold_r, r_hold_u, r_hold_d;
  logic r_done, r_collision;
`ifdef COLLISION_HITCOUNT_EN
  logic [CNT_W-1:0] r_cnt, r_hit_count;
`endif
  // Bounding box in tiles; right/bottom sums are one bit wider so they cannot wrap
  always_comb begin
    w_x0r = {1'b0, spriteX} / SW'(TILE_PX);
    w_x1r = ({1'b0, spriteX} + SW'(spriteWidth)) / SW'(TILE_PX);
    w_y0r = {1'b0, spriteY} / SW'(TILE_PX);
    w_y1r = ({1'b0, spriteY} + SW'(spriteHeight)) / SW'(TILE_PX);
    w_x0 = w_x0r >= SW'(MAP_W) ? XW'(MAP_W - 1) : w_x0r[XW-1:0];
    w_x1 = w_x1r >= SW'(MAP_W) ? XW'(MAP_W - 1) : w_x1r[XW-1:0];
    w_y0 = w_y0r >= SW'(MAP_H) ? YW'(MAP_H - 1) : w_y0r[YW-1:0];
    w_y1 = w_y1r >= SW'(MAP_H) ? YW'(MAP_H - 1) : w_y1r[YW-1:0];
    w_idx = IW'(r_ty) * IW'(MAP_W) + IW'(r_tx);
    w_solid = map[w_idx];
    w_last = (r_tx == r_x1) && (r_ty == r_y1);
  end
  // State register
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) r_state <= IDLE;
    else r_state <= w_next;
  // Next-state logic; start outside IDLE is simply dropped
  always_comb
    w_next = r_state == IDLE ? (start ? LATCH : IDLE) :
             r_state == LATCH ? SCAN :
             r_state == SCAN ? (w_last ? RESOLVE : SCAN) : IDLE;
  // Output/resolve logic: left beats right, up beats down, axes independent
  always_comb begin
    busy = r_state != IDLE;
    done = r_done;
    collision = r_collision;
    bounceLeft = r_hold_l != '0;
    bounceRight = r_hold_r != '0;
    bounceUp = r_hold_u != '0;
    bounceDown = r_hold_d != '0;
    w_trig_r = r_dl && r_hit_l;
    w_trig_l = !w_trig_r && r_dr && (r_hit_r || r_oob_r);
    w_trig_d = r_du && r_hit_t;
    w_trig_u = !w_trig_d && r_dd && (r_hit_b || r_oob_b);
`ifdef COLLISION_HITCOUNT_EN
    hit_count = r_hit_count;
`else
    hit_count = '0;
`endif
  end
  // Scan datapath: latch box and direction, then walk tiles row-major accumulating edge hits
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      {r_x0, r_x1, r_tx, r_y0, r_y1, r_ty} <= '0;
      {r_oob_r, r_oob_b, r_dl, r_dr, r_du, r_dd} <= '0;
      {r_hit_l, r_hit_r, r_hit_t, r_hit_b, r_hit_any} <= '0;
    end else if (r_state == LATCH) begin
      {r_x0, r_tx, r_x1} <= {w_x0, w_x0, w_x1};
      {r_y0, r_ty, r_y1} <= {w_y0, w_y0, w_y1};
      r_oob_r <= w_x1r >= SW'(MAP_W);
      r_oob_b <= w_y1r >= SW'(MAP_H);
      {r_dl, r_dr, r_du, r_dd} <= {left, right, up, down};
      {r_hit_l, r_hit_r, r_hit_t, r_hit_b, r_hit_any} <= '0;
    end else if (r_state == SCAN) begin
      r_tx <= r_tx == r_x1 ? r_x0 : r_tx + 1'b1;
      r_ty <= r_tx == r_x1 ? r_ty + 1'b1 : r_ty;
      r_hit_any <= r_hit_any | w_solid;
      r_hit_l <= r_hit_l | (w_solid && r_tx == r_x0);
      r_hit_r <= r_hit_r | (w_solid && r_tx == r_x1);
      r_hit_t <= r_hit_t | (w_solid && r_ty == r_y0);
      r_hit_b <= r_hit_b | (w_solid && r_ty == r_y1);
    end
`ifdef COLLISION_HITCOUNT_EN
  // Saturating solid-tile counter for the current scan
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) r_cnt <= '0;
    else if (r_state == LATCH) r_cnt <= '0;
    else if (r_state == SCAN && w_solid && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
`endif
  function automatic logic [HW-1:0] hold_next(input logic [HW-1:0] c, input logic trig, input logic opp);
    return trig ? HW'(BOUNCE_HOLD) : opp ? '0 : (c != '0 ? c - 1'b1 : '0);
  endfunction
  // Frame results: hold counters, collision and hit count all change on the done edge
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      {r_hold_l, r_hold_r, r_hold_u, r_hold_d} <= '0;
      {r_done, r_collision} <= '0;
`ifdef COLLISION_HITCOUNT_EN
      r_hit_count <= '0;
`endif
    end else begin
      r_done <= r_state == RESOLVE;
      if (r_state == RESOLVE) begin
        r_hold_l <= hold_next(r_hold_l, w_trig_l, w_trig_r);
        r_hold_r <= hold_next(r_hold_r, w_trig_r, w_trig_l);
        r_hold_u <= hold_next(r_hold_u, w_trig_u, w_trig_d);
        r_hold_d <= hold_next(r_hold_d, w_trig_d, w_trig_u);
        r_collision <= r_hit_any;
`ifdef COLLISION_HITCOUNT_EN
        r_hit_count <= r_cnt;
`endif
      end
    end
endmodule

// File: tb/tb_tile_collision_scanner.sv
// tb_tile_collision_scanner: directed checks of scan latency, edge classification, bounce hold and reset
module tb_tile_collision_scanner;
  localparam int MW = 64, MH = 48;
  logic Clk = 0, Reset = 1, start = 0;
  logic [MW*MH-1:0] map = '0;
  logic [19:0] spriteX = 0, spriteY = 0;
  logic [9:0] spriteWidth = 0, spriteHeight = 0;
  logic left = 0, right = 0, up = 0, down = 0;
  logic busy, done, bounceLeft, bounceRight, bounceUp, bounceDown, collision;
  logic [11:0] hit_count;
  int checks = 0, errors = 0;
  tile_collision_scanner #(.BOUNCE_HOLD(2)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .map(map),
    .spriteX(spriteX), .spriteY(spriteY), .spriteWidth(spriteWidth), .spriteHeight(spriteHeight),
    .left(left), .right(right), .up(up), .down(down),
    .busy(busy), .done(done), .bounceLeft(bounceLeft), .bounceRight(bounceRight),
    .bounceUp(bounceUp), .bounceDown(bounceDown), .collision(collision), .hit_count(hit_count)
  );
  always #5 Clk = ~Clk;
  function automatic int hc(input int n);
`ifdef COLLISION_HITCOUNT_EN
    return n;
`else
    return 0;
`endif
  endfunction
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic scan(input string tag, input int n);
    int cyc;
    @(negedge Clk); start = 1;
    @(negedge Clk); start = 0; cyc = 0;
    while (!done && cyc < 200) begin @(negedge Clk); cyc++; end
    chk({tag, " latency"}, cyc, n + 2);
  endtask
  function automatic int lrud();
    return {28'd0, bounceLeft, bounceRight, bounceUp, bounceDown};
  endfunction
  initial begin
    int pulses;
    #2;
    chk("reset busy", busy, 0);
    chk("reset outs", {done, collision, bounceLeft, bounceRight, bounceUp, bounceDown}, 0);
    chk("reset count", hit_count, 0);
    @(negedge Clk); Reset = 0;
    map[650] = 1; spriteX = 100; spriteY = 100; spriteWidth = 9; spriteHeight = 9; left = 1;
    scan("t1", 1);
    chk("t1 bounce", lrud(), 4'b0100);
    chk("t1 collision", collision, 1);
    chk("t1 count", hit_count, hc(1));
    map = '0;
    scan("t2a", 1);
    chk("t2a bounce", lrud(), 4'b0100);
    chk("t2a collision", collision, 0);
    scan("t2b", 1);
    chk("t2b bounce", lrud(), 4'b0000);
    scan("t2c", 1);
    chk("t2c bounce", lrud(), 4'b0000);
    map[651] = 1; spriteWidth = 25; spriteHeight = 5;
    scan("t3", 3);
    chk("t3 collision", collision, 1);
    chk("t3 bounce", lrud(), 4'b0000);
    chk("t3 count", hit_count, hc(1));
    map = '0; spriteX = 630; spriteWidth = 15; spriteY = 0; spriteHeight = 5; left = 0; right = 1;
    scan("t4a", 1);
    chk("t4a bounce", lrud(), 4'b1000);
    chk("t4a collision", collision, 0);
    map[63] = 1; left = 1;
    scan("t4b", 1);
    chk("t4b bounce", lrud(), 4'b0100);
    chk("t4b collision", collision, 1);
    map = '0; left = 0; right = 0; spriteX = 0; spriteWidth = 50;
    @(negedge Clk); start = 1;
    @(negedge Clk); start = 0;
    @(negedge Clk);
    chk("t5 busy in scan", busy, 1);
    start = 1;
    @(negedge Clk); start = 0; pulses = 0;
    repeat (15) begin @(negedge Clk); if (done) pulses++; end
    chk("t5 done pulses", pulses, 1);
    chk("t5 idle after", busy, 0);
    chk("t5 bounce", lrud(), 4'b0100);
    @(negedge Clk); start = 1;
    @(negedge Clk); start = 0;
    @(negedge Clk); @(negedge Clk);
    chk("t5 busy before rst", busy, 1);
    #2 Reset = 1;
    #1;
    chk("t5 rst busy", busy, 0);
    chk("t5 rst outs", {done, collision, bounceLeft, bounceRight, bounceUp, bounceDown}, 0);
    chk("t5 rst count", hit_count, 0);
    @(negedge Clk); Reset = 0;
    map[650] = 1; map[778] = 1; spriteX = 100; spriteY = 100; spriteWidth = 5; spriteHeight = 25; up = 1; left = 1;
    scan("t6", 3);
    chk("t6 bounce", lrud(), 4'b0101);
    chk("t6 collision", collision, 1);
    chk("t6 count", hit_count, hc(2));
    @(negedge Clk);
    chk("t6 done pulse", done, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
